ps2_rx: RTL and testbench



---
 rtl/ps2_rx.sv | 169 ++++++++++++++++
 tb/tb_ps2_rx.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx.sv
// PS/2 receive-only front end: synchronises the device clock/data pins,
// deframes 11-bit frames (start, 8 data LSB first, odd parity, stop),
// reports framing/parity/overflow as one-cycle pulses and buffers good
// bytes in a small FIFO drained by rd_en.
//
// state  | meaning
// IDLE   | waiting for a start-bit falling edge
// DATA   | shifting in the 8 data bits
// PARITY | waiting for the parity bit
// STOP   | waiting for the stop bit, then decide push/error
module ps2_rx #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic       rd_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state, state_nxt;
  logic          clk_s1, sclk, dat_s1, sdat, prev_sclk;
  logic          fe;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          timeout;
  logic          push, pop, full, empty;
  logic          perr_nxt, ferr_nxt, ovf_nxt;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [7:0]    mem [FIFO_DEPTH];

  // Two-flop synchronisers plus previous-clock register; all idle high.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      clk_s1    <= 1'b1;
      sclk      <= 1'b1;
      dat_s1    <= 1'b1;
      sdat      <= 1'b1;
      prev_sclk <= 1'b1;
    end else begin
      clk_s1    <= ps2_clk;
      sclk      <= clk_s1;
      dat_s1    <= ps2_dat;
      sdat      <= dat_s1;
      prev_sclk <= sclk;
    end
  end

  assign fe      = prev_sclk & ~sclk;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = rd_en & ~empty;
  assign timeout = (state != IDLE) && !fe && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and frame outcome decision on the stop-bit edge.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    perr_nxt  = 1'b0;
    ferr_nxt  = 1'b0;
    ovf_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (fe) begin
          if (!sdat) state_nxt = DATA;
          else       ferr_nxt  = 1'b1;
        end
      end
      DATA: begin
        if (fe && bit_cnt == 3'd7) state_nxt = PARITY;
      end
      PARITY: begin
        if (fe) state_nxt = STOP;
      end
      STOP: begin
        if (fe) begin
          state_nxt = IDLE;
          if (!sdat)                     ferr_nxt = 1'b1;
          else if (!(^{shreg, par_bit})) perr_nxt = 1'b1;
          else if (full && !rd_en)       ovf_nxt  = 1'b1;
          else                           push     = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (timeout) begin
      state_nxt = IDLE;
      ferr_nxt  = 1'b1;
    end
  end

  // Shift register, bit counter and parity latch.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
      par_bit <= 1'b0;
    end else if (fe) begin
      if (state == IDLE && !sdat) begin
        bit_cnt <= 3'd0;
        shreg   <= 8'h00;
      end else if (state == DATA) begin
        shreg   <= {sdat, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end else if (state == PARITY) begin
        par_bit <= sdat;
      end
    end
  end

  // Inter-edge timeout counter; held at zero while idle so it cannot re-fire.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)                                   to_cnt <= '0;
    else if (fe || state == IDLE)                 to_cnt <= '0;
    else if (to_cnt != TW'(TIMEOUT_CYCLES))       to_cnt <= to_cnt + 1'b1;
  end

  // Registered one-cycle status pulses.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      parity_err <= perr_nxt;
      frame_err  <= ferr_nxt;
      overflow   <= ovf_nxt;
    end
  end

  // FIFO pointers; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= shreg;
  end

  assign rx_valid = ~empty;
  assign rx_data  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: directed frames from the test plan plus
// randomized frames checked against a queue-based reference model.
module tb_ps2_rx;

  localparam int TO    = 500;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, overflow;

  int total = 0;
  int bad   = 0;
  int cyc = 0, n_perr = 0, n_ferr = 0, n_ovf = 0, last_ferr_cyc = 0;
  int last_fall_cyc = 0;

  ps2_rx #(.TIMEOUT_CYCLES(TO), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_b(rst_b), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .rd_en(rd_en), .rx_data(rx_data), .rx_valid(rx_valid),
    .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (parity_err) n_perr <= n_perr + 1;
    if (overflow)   n_ovf  <= n_ovf + 1;
    if (frame_err) begin
      n_ferr        <= n_ferr + 1;
      last_ferr_cyc <= cyc;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: time limit reached, required $finish before 3ms");
    $fatal(1, "watchdog");
  end

  task automatic ps2_bit(input logic b, input int half);
    @(negedge clk) ps2_dat = b;
    repeat (half - 1) @(negedge clk);
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    repeat (half) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // Full frame; the stop bit is handled by hand to sample around the push cycle.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input int half, input bit rd_at_push,
                            output logic pre_v, output logic post_v,
                            output logic [7:0] post_d);
    ps2_bit(1'b0, half);
    for (int i = 0; i < 8; i++) ps2_bit(d[i], half);
    ps2_bit(par, half);
    @(negedge clk) ps2_dat = stp;
    repeat (half - 1) @(negedge clk);
    ps2_clk = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    pre_v = rx_valid;
    if (rd_at_push) rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en  = 1'b0;
    post_v = rx_valid;
    post_d = rx_data;
    repeat (half) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pop_one();
    @(negedge clk) rd_en = 1'b1;
    @(negedge clk) rd_en = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({rx_valid, rx_data, parity_err, frame_err, overflow} !== 12'h0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b d=%h pe=%b fe=%b ov=%b, want all 0",
               rx_valid, rx_data, parity_err, frame_err, overflow);
    end
    rst_b = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if (n_ferr !== 0 || rx_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got ferr=%0d v=%b, want 0 0", n_ferr, rx_valid);
    end
  endtask

  task automatic test_basic();
    logic pv, v; logic [7:0] d;
    int pe0 = n_perr, fe0 = n_ferr, ov0 = n_ovf;
    send_frame(8'h1C, 1'b0, 1'b1, 40, 1'b0, pv, v, d);
    total++;
    if (pv !== 1'b0 || v !== 1'b1 || d !== 8'h1C) begin
      bad++;
      $display("FAIL basic_latency: got pre_v=%b v=%b d=%h, want 0 1 1c", pv, v, d);
    end
    pop_one();
    #1;
    total++;
    if (rx_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_pop: got v=%b, want 0", rx_valid);
    end
    total++;
    if (n_perr != pe0 || n_ferr != fe0 || n_ovf != ov0) begin
      bad++;
      $display("FAIL basic_noerr: got pe=%0d fe=%0d ov=%0d new pulses, want 0",
               n_perr - pe0, n_ferr - fe0, n_ovf - ov0);
    end
  endtask

  task automatic test_parity();
    logic pv, v; logic [7:0] d;
    int pe0 = n_perr, fe0 = n_ferr;
    send_frame(8'hF0, 1'b0, 1'b1, 40, 1'b0, pv, v, d);
    total++;
    if (n_perr - pe0 != 1 || n_ferr != fe0 || v !== 1'b0) begin
      bad++;
      $display("FAIL parity_err: got pe=%0d fe=%0d v=%b, want 1 0 0",
               n_perr - pe0, n_ferr - fe0, v);
    end
  endtask

  task automatic test_frame_err();
    logic pv, v; logic [7:0] d;
    int pe0 = n_perr, fe0 = n_ferr;
    send_frame(8'h55, 1'b1, 1'b0, 40, 1'b0, pv, v, d);
    total++;
    if (n_ferr - fe0 != 1 || n_perr != pe0 || v !== 1'b0) begin
      bad++;
      $display("FAIL stop_err: got fe=%0d pe=%0d v=%b, want 1 0 0",
               n_ferr - fe0, n_perr - pe0, v);
    end
    fe0 = n_ferr;
    ps2_bit(1'b1, 40);
    repeat (4) @(negedge clk);
    total++;
    if (n_ferr - fe0 != 1) begin
      bad++;
      $display("FAIL idle_start1: got fe=%0d, want 1", n_ferr - fe0);
    end
    send_frame(8'h12, ~^8'h12, 1'b1, 40, 1'b0, pv, v, d);
    total++;
    if (v !== 1'b1 || d !== 8'h12) begin
      bad++;
      $display("FAIL idle_stays: got v=%b d=%h, want 1 12", v, d);
    end
    pop_one();
  endtask

  task automatic test_timeout();
    logic pv, v; logic [7:0] d;
    int fe0 = n_ferr, dt;
    ps2_bit(1'b0, 40);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1, 40);
    repeat (600) @(negedge clk);
    dt = last_ferr_cyc - last_fall_cyc;
    total++;
    if (n_ferr - fe0 != 1) begin
      bad++;
      $display("FAIL timeout_count: got fe=%0d, want 1", n_ferr - fe0);
    end
    total++;
    if (dt < TO - 10 || dt > TO + 15) begin
      bad++;
      $display("FAIL timeout_time: got %0d cycles after last fall, want about %0d", dt, TO);
    end
    send_frame(8'h29, ~^8'h29, 1'b1, 40, 1'b0, pv, v, d);
    total++;
    if (v !== 1'b1 || d !== 8'h29) begin
      bad++;
      $display("FAIL timeout_recover: got v=%b d=%h, want 1 29", v, d);
    end
    pop_one();
  endtask

  task automatic test_back_to_back();
    logic pv, v; logic [7:0] d, b;
    logic [7:0] exp_q [$] = '{8'h02, 8'h03, 8'h04, 8'h06};
    int ov0 = n_ovf;
    for (int i = 1; i <= 5; i++) begin
      b = 8'(i);
      send_frame(b, ~^b, 1'b1, 20, 1'b0, pv, v, d);
    end
    total++;
    if (n_ovf - ov0 != 1 || rx_data !== 8'h01) begin
      bad++;
      $display("FAIL overflow_5th: got ov=%0d head=%h, want 1 01", n_ovf - ov0, rx_data);
    end
    ov0 = n_ovf;
    send_frame(8'h06, ~^8'h06, 1'b1, 20, 1'b1, pv, v, d);
    total++;
    if (n_ovf != ov0 || v !== 1'b1 || d !== 8'h02) begin
      bad++;
      $display("FAIL full_push_pop: got ov=%0d v=%b head=%h, want 0 1 02", n_ovf - ov0, v, d);
    end
    foreach (exp_q[i]) begin
      #1;
      total++;
      if (rx_valid !== 1'b1 || rx_data !== exp_q[i]) begin
        bad++;
        $display("FAIL drain_%0d: got v=%b d=%h, want 1 %h", i, rx_valid, rx_data, exp_q[i]);
      end
      pop_one();
    end
    #1;
    total++;
    if (rx_valid !== 1'b0) begin
      bad++;
      $display("FAIL drain_empty: got v=%b, want 0", rx_valid);
    end
    pop_one();
    #1;
    total++;
    if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin
      bad++;
      $display("FAIL pop_empty: got v=%b d=%h, want 0 00", rx_valid, rx_data);
    end
  endtask

  task automatic test_mid_reset();
    logic pv, v; logic [7:0] d;
    send_frame(8'h77, ~^8'h77, 1'b1, 20, 1'b0, pv, v, d);
    ps2_bit(1'b0, 20);
    for (int i = 0; i < 5; i++) ps2_bit(1'($urandom_range(0, 1)), 20);
    @(negedge clk) rst_b = 1'b0;
    #1;
    total++;
    if ({rx_valid, rx_data, parity_err, frame_err, overflow} !== 12'h0) begin
      bad++;
      $display("FAIL midreset_outputs: got v=%b d=%h pe=%b fe=%b ov=%b, want all 0",
               rx_valid, rx_data, parity_err, frame_err, overflow);
    end
    @(negedge clk) rst_b = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'h3A, ~^8'h3A, 1'b1, 20, 1'b0, pv, v, d);
    total++;
    if (pv !== 1'b0 || v !== 1'b1 || d !== 8'h3A) begin
      bad++;
      $display("FAIL midreset_next: got pre_v=%b v=%b d=%h, want 0 1 3a", pv, v, d);
    end
    pop_one();
  endtask

  // Randomized frames against a queue model of the receive path.
  task automatic test_random();
    logic pv, v; logic [7:0] d, b;
    logic par, stp;
    logic [7:0] q [$];
    int pe0, fe0, ov0, e_pe, e_fe, e_ov, k;
    for (int n = 0; n < 24; n++) begin
      k = $urandom_range(0, 2);
      for (int j = 0; j < k; j++) begin
        #1;
        total++;
        if (q.size() > 0) begin
          if (rx_valid !== 1'b1 || rx_data !== q[0]) begin
            bad++;
            $display("FAIL rand_head_%0d: got v=%b d=%h, want 1 %h", n, rx_valid, rx_data, q[0]);
          end
          void'(q.pop_front());
        end else if (rx_valid !== 1'b0) begin
          bad++;
          $display("FAIL rand_empty_%0d: got v=%b, want 0", n, rx_valid);
        end
        pop_one();
      end
      b   = 8'($urandom);
      par = ($urandom_range(0, 4) != 0) ? ~^b : ^b;
      stp = ($urandom_range(0, 9) != 0);
      e_pe = 0; e_fe = 0; e_ov = 0;
      if (!stp)                 e_fe = 1;
      else if ((^b ^ par) != 1) e_pe = 1;
      else if (q.size() == DEPTH) e_ov = 1;
      else                      q.push_back(b);
      pe0 = n_perr; fe0 = n_ferr; ov0 = n_ovf;
      send_frame(b, par, stp, $urandom_range(8, 30), 1'b0, pv, v, d);
      total++;
      if (n_perr - pe0 != e_pe || n_ferr - fe0 != e_fe || n_ovf - ov0 != e_ov ||
          v !== (q.size() > 0) || (q.size() > 0 && d !== q[0])) begin
        bad++;
        $display("FAIL rand_frame_%0d: byte %h got pe=%0d fe=%0d ov=%0d v=%b d=%h, want %0d %0d %0d %b %h",
                 n, b, n_perr - pe0, n_ferr - fe0, n_ovf - ov0, v, d, e_pe, e_fe, e_ov,
                 q.size() > 0, (q.size() > 0) ? q[0] : 8'h00);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_frame_err();
    test_timeout();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
